// File: rtl/gcd_pkg.sv
// Shared definitions for the multi-channel GCD peripheral: channel FSM states,
// register offsets and CTRL/STATUS bit positions.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } gcd_state_e;

  // Per-channel offsets within a 16-byte channel window
  localparam logic [3:0] OFF_A      = 4'h0;
  localparam logic [3:0] OFF_B      = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_RESULT = 4'hC;

  // Global offsets within the 512-byte window
  localparam logic [8:0] OFF_IRQ_EN   = 9'h100;
  localparam logic [8:0] OFF_IRQ_PEND = 9'h104;

  localparam int CTRL_START   = 0;
  localparam int CTRL_CLR_OVR = 1;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_OVR  = 2;

endpackage

// File: rtl/gcd_engine.sv
// One GCD channel: A/B shadow registers, subtractive engine on x/y, RESULT,
// IDLE/BUSY/DONE FSM and the sticky overrun flag.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             a_we_i,
  input  logic             b_we_i,
  input  logic             start_i,
  input  logic             clr_ovr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] result_o,
  output logic [2:0]       status_o,
  output logic             done_pulse_o
);

  gcd_state_e       state_q;
  logic [WIDTH-1:0] a_q, b_q, x_q, y_q, result_q;
  logic             ovr_q;
  logic             term_d;

  // Terminal check for the current BUSY cycle; the FSM enters DONE on this edge
  assign term_d       = (x_q == y_q) || (y_q == '0) || (x_q == '0);
  assign done_pulse_o = (state_q == BUSY) && term_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      if (a_we_i) a_q <= wdata_i;
      if (b_we_i) b_q <= wdata_i;
      if (clr_ovr_i) ovr_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            x_q     <= a_q;
            y_q     <= b_q;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (start_i) ovr_q <= 1'b1;
          if ((x_q == y_q) || (y_q == '0)) begin
            result_q <= x_q;
            state_q  <= DONE;
          end else if (x_q == '0) begin
            result_q <= y_q;
            state_q  <= DONE;
          end else if (x_q > y_q) begin
            x_q <= x_q - y_q;
          end else begin
            y_q <= y_q - x_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_o      = a_q;
  assign b_o      = b_q;
  assign result_o = result_q;

  always_comb begin
    status_o          = '0;
    status_o[ST_BUSY] = (state_q == BUSY);
    status_o[ST_DONE] = (state_q == DONE);
    status_o[ST_OVR]  = ovr_q;
  end

endmodule

// File: rtl/gcd_array_peripheral.sv
// Memory-mapped array of NUM_CH GCD engines with per-channel interrupt
// enable/pending bits combined into one level interrupt.
module gcd_array_peripheral
  import gcd_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_F000,
  parameter int          NUM_CH    = 4,
  parameter int          WIDTH     = 32
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        irq_o
);

  logic              sel;
  logic [8:0]        off;
  logic              glob_we;
  logic [NUM_CH-1:0] done_vec;
  logic [NUM_CH-1:0] irq_en_q, irq_pend_q, irq_pend_d;
  logic [WIDTH-1:0]  a_arr   [NUM_CH];
  logic [WIDTH-1:0]  b_arr   [NUM_CH];
  logic [WIDTH-1:0]  res_arr [NUM_CH];
  logic [2:0]        st_arr  [NUM_CH];

  assign sel     = (data_addr_i[31:9] == BASE_ADDR[31:9]);
  assign off     = data_addr_i[8:0];
  assign glob_we = sel && data_we_i && off[8];

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic ch_we;
    assign ch_we = sel && data_we_i && !off[8] && (off[7:4] == 4'(n));

    gcd_engine #(.WIDTH(WIDTH)) u_eng (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .a_we_i       (ch_we && (off[3:0] == OFF_A)),
      .b_we_i       (ch_we && (off[3:0] == OFF_B)),
      .start_i      (ch_we && (off[3:0] == OFF_CTRL) && data_wdata_i[CTRL_START]),
      .clr_ovr_i    (ch_we && (off[3:0] == OFF_CTRL) && data_wdata_i[CTRL_CLR_OVR]),
      .wdata_i      (data_wdata_i[WIDTH-1:0]),
      .a_o          (a_arr[n]),
      .b_o          (b_arr[n]),
      .result_o     (res_arr[n]),
      .status_o     (st_arr[n]),
      .done_pulse_o (done_vec[n])
    );
  end

  // A completion on the same edge as a W1C of that bit leaves the bit set
  always_comb begin
    irq_pend_d = irq_pend_q;
    if (glob_we && (off == OFF_IRQ_PEND)) irq_pend_d = irq_pend_d & ~data_wdata_i[NUM_CH-1:0];
    irq_pend_d = irq_pend_d | done_vec;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      irq_en_q   <= '0;
      irq_pend_q <= '0;
    end else begin
      if (glob_we && (off == OFF_IRQ_EN)) irq_en_q <= data_wdata_i[NUM_CH-1:0];
      irq_pend_q <= irq_pend_d;
    end
  end

  assign irq_o = |(irq_pend_q & irq_en_q);

  always_comb begin
    data_rdata_o = '0;
    if (sel) begin
      if (off == OFF_IRQ_EN) begin
        data_rdata_o[NUM_CH-1:0] = irq_en_q;
      end else if (off == OFF_IRQ_PEND) begin
        data_rdata_o[NUM_CH-1:0] = irq_pend_q;
      end else if (!off[8]) begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (off[7:4] == 4'(n)) begin
            case (off[3:0])
              OFF_A:      data_rdata_o[WIDTH-1:0] = a_arr[n];
              OFF_B:      data_rdata_o[WIDTH-1:0] = b_arr[n];
              OFF_CTRL:   data_rdata_o[2:0]       = st_arr[n];
              OFF_RESULT: data_rdata_o[WIDTH-1:0] = res_arr[n];
              default:    ;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gcd_array_peripheral.sv
// Self-checking bench for gcd_array_peripheral: directed scenarios plus random
// operands checked against a quotient-sum model of result and latency.
module tb_gcd_array_peripheral;

  localparam logic [31:0] BASE = 32'h0000_F000;
  localparam int          NCH  = 4;
  localparam logic [31:0] R_A = 32'h0, R_B = 32'h4, R_CTRL = 32'h8, R_RES = 32'hC;
  localparam logic [31:0] R_EN = 32'h100, R_PEND = 32'h104;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  int          checks = 0;
  int          failures = 0;

  gcd_array_peripheral #(.BASE_ADDR(BASE), .NUM_CH(NCH), .WIDTH(32)) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .data_addr_i  (addr),
    .data_we_i    (we),
    .data_wdata_i (wdata),
    .data_rdata_o (rdata),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ca(input int ch, input logic [31:0] r);
    return BASE + 32'(ch) * 32'h10 + r;
  endfunction

  // Reference: Euclid by remainder
  function automatic logic [31:0] model_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, r;
    x = a; y = b;
    while (y != 0) begin r = x % y; x = y; y = r; end
    return x;
  endfunction

  // Cycles from START to DONE: subtractions equal the quotient sum minus one,
  // plus one terminal-check cycle; any zero operand finishes in one cycle.
  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, r;
    int s;
    if (a == 0 || b == 0) return 1;
    x = (a > b) ? a : b;
    y = (a > b) ? b : a;
    s = 0;
    while (y != 0) begin s += int'(x / y); r = x % y; x = y; y = r; end
    return s;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic rd_now(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1 d = rdata;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    rd_now(a, d);
  endtask

  // k = number of edges after the last write edge at which DONE was first seen
  task automatic poll_done(input int ch, input int budget, output int k);
    logic [31:0] s;
    k = 0;
    forever begin
      @(negedge clk);
      rd_now(ca(ch, R_CTRL), s);
      if (s[1]) break;
      k++;
      if (k > budget) break;
    end
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst = 1'b1; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    for (int ch = 0; ch < NCH; ch++) begin
      for (int r = 0; r < 4; r++) begin
        rd(ca(ch, 32'(r * 4)), v);
        checks++;
        if (v !== 32'd0) begin failures++; $display("FAIL reset_reg ch%0d off%0d got=%h exp=0", ch, r * 4, v); end
      end
    end
    rd(BASE + R_EN, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL reset_en got=%h exp=0", v); end
    rd(BASE + R_PEND, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL reset_pend got=%h exp=0", v); end
  endtask

  task automatic test_basic;
    logic [31:0] v;
    int k;
    wr(ca(0, R_A), 32'd12);
    wr(ca(0, R_B), 32'd18);
    wr(ca(0, R_CTRL), 32'd1);
    poll_done(0, 50, k);
    checks++;
    if (k !== 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", k); end
    rd_now(ca(0, R_CTRL), v);
    checks++;
    if (v !== 32'd2) begin failures++; $display("FAIL basic_status got=%h exp=2", v); end
    rd_now(ca(0, R_RES), v);
    checks++;
    if (v !== 32'd6) begin failures++; $display("FAIL basic_result got=%0d exp=6", v); end
    rd_now(BASE + R_PEND, v);
    checks++;
    if (v !== 32'd1) begin failures++; $display("FAIL basic_pend got=%h exp=1", v); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL basic_irq_masked got=%b exp=0", irq); end
  endtask

  task automatic test_zero_irq;
    logic [31:0] v;
    int k;
    wr(BASE + R_PEND, 32'hF);
    wr(BASE + R_EN, 32'h2);
    wr(ca(1, R_A), 32'd0);
    wr(ca(1, R_B), 32'd35);
    wr(ca(1, R_CTRL), 32'd1);
    poll_done(1, 20, k);
    checks++;
    if (k !== 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", k); end
    rd_now(ca(1, R_RES), v);
    checks++;
    if (v !== 32'd35) begin failures++; $display("FAIL zero_result got=%0d exp=35", v); end
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL zero_irq_set got=%b exp=1", irq); end
    wr(BASE + R_PEND, 32'h2);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL zero_irq_clr got=%b exp=0", irq); end
    wr(ca(1, R_B), 32'd0);
    wr(ca(1, R_CTRL), 32'd1);
    poll_done(1, 20, k);
    checks++;
    if (k !== 1) begin failures++; $display("FAIL zerozero_latency got=%0d exp=1", k); end
    rd_now(ca(1, R_RES), v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL zerozero_result got=%0d exp=0", v); end
    rd_now(BASE + R_PEND, v);
    checks++;
    if (v !== 32'h2) begin failures++; $display("FAIL zerozero_pend got=%h exp=2", v); end
    wr(BASE + R_PEND, 32'hF);
    wr(BASE + R_EN, 32'h0);
  endtask

  task automatic test_concurrency;
    logic [31:0] s0, s3, p, expp;
    int l0, l3, f0, f3;
    l0 = model_lat(32'd48, 32'd36);
    l3 = model_lat(32'd17, 32'd5) + 1;
    f0 = -1; f3 = -1;
    wr(ca(0, R_A), 32'd48);
    wr(ca(0, R_B), 32'd36);
    wr(ca(3, R_A), 32'd17);
    wr(ca(3, R_B), 32'd5);
    wr(ca(0, R_CTRL), 32'd1);
    wr(ca(3, R_CTRL), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      rd_now(ca(0, R_CTRL), s0);
      rd_now(ca(3, R_CTRL), s3);
      rd_now(BASE + R_PEND, p);
      if (s0[1] && f0 < 0) f0 = k;
      if (s3[1] && f3 < 0) f3 = k;
      expp = ((k >= l0) ? 32'h1 : 32'h0) | ((k >= l3) ? 32'h8 : 32'h0);
      checks++;
      if (p !== expp) begin failures++; $display("FAIL conc_pend k=%0d got=%h exp=%h", k, p, expp); end
    end
    checks++;
    if (f0 !== l0) begin failures++; $display("FAIL conc_lat_ch0 got=%0d exp=%0d", f0, l0); end
    checks++;
    if (f3 !== l3) begin failures++; $display("FAIL conc_lat_ch3 got=%0d exp=%0d", f3, l3); end
    rd(ca(0, R_RES), s0);
    checks++;
    if (s0 !== model_gcd(32'd48, 32'd36)) begin failures++; $display("FAIL conc_res_ch0 got=%0d exp=12", s0); end
    rd(ca(3, R_RES), s3);
    checks++;
    if (s3 !== model_gcd(32'd17, 32'd5)) begin failures++; $display("FAIL conc_res_ch3 got=%0d exp=1", s3); end
    wr(BASE + R_PEND, 32'hF);
  endtask

  task automatic test_overrun;
    logic [31:0] v;
    int k;
    wr(ca(2, R_A), 32'd1000);
    wr(ca(2, R_B), 32'd1);
    wr(ca(2, R_CTRL), 32'd1);
    wr(ca(2, R_A), 32'd7);
    wr(ca(2, R_CTRL), 32'd1);
    @(negedge clk);
    rd_now(ca(2, R_CTRL), v);
    checks++;
    if (v !== 32'h5) begin failures++; $display("FAIL ovr_status_busy got=%h exp=5", v); end
    poll_done(2, 2000, k);
    checks++;
    if (k + 3 !== model_lat(32'd1000, 32'd1)) begin failures++; $display("FAIL ovr_latency got=%0d exp=%0d", k + 3, model_lat(32'd1000, 32'd1)); end
    rd_now(ca(2, R_CTRL), v);
    checks++;
    if (v !== 32'h6) begin failures++; $display("FAIL ovr_status_done got=%h exp=6", v); end
    rd_now(ca(2, R_RES), v);
    checks++;
    if (v !== 32'd1) begin failures++; $display("FAIL ovr_result got=%0d exp=1", v); end
    wr(ca(2, R_CTRL), 32'h2);
    rd(ca(2, R_CTRL), v);
    checks++;
    if (v !== 32'h2) begin failures++; $display("FAIL ovr_clear got=%h exp=2", v); end
    rd(ca(2, R_A), v);
    checks++;
    if (v !== 32'd7) begin failures++; $display("FAIL shadow_a got=%0d exp=7", v); end
    wr(ca(2, R_B), 32'd35);
    wr(ca(2, R_CTRL), 32'd1);
    poll_done(2, 50, k);
    rd_now(ca(2, R_RES), v);
    checks++;
    if (v !== model_gcd(32'd7, 32'd35)) begin failures++; $display("FAIL shadow_result got=%0d exp=7", v); end
    checks++;
    if (k !== model_lat(32'd7, 32'd35)) begin failures++; $display("FAIL shadow_latency got=%0d exp=%0d", k, model_lat(32'd7, 32'd35)); end
    wr(BASE + R_PEND, 32'hF);
  endtask

  task automatic test_w1c_race;
    logic [31:0] v;
    wr(BASE + R_PEND, 32'hF);
    wr(ca(0, R_A), 32'd12);
    wr(ca(0, R_B), 32'd18);
    wr(ca(0, R_CTRL), 32'd1);
    repeat (2) @(posedge clk);
    wr(BASE + R_PEND, 32'h1);
    @(negedge clk);
    rd_now(ca(0, R_CTRL), v);
    checks++;
    if (v !== 32'h2) begin failures++; $display("FAIL race_status got=%h exp=2", v); end
    rd_now(BASE + R_PEND, v);
    checks++;
    if (v !== 32'h1) begin failures++; $display("FAIL race_pend got=%h exp=1", v); end
    wr(BASE + R_PEND, 32'h1);
    rd(BASE + R_PEND, v);
    checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL race_pend_clear got=%h exp=0", v); end
  endtask

  task automatic test_random;
    logic [31:0] a, b, v, en;
    int ch, k;
    for (int t = 0; t < 8; t++) begin
      ch = int'($urandom_range(0, NCH - 1));
      a  = $urandom_range(0, 1500);
      b  = $urandom_range(1, 1500);
      if ($urandom_range(0, 5) == 0) a = 32'd0;
      if ($urandom_range(0, 5) == 0) b = a;
      en = $urandom_range(0, 15);
      wr(BASE + R_PEND, 32'hF);
      wr(BASE + R_EN, en);
      wr(ca(ch, R_A), a);
      wr(ca(ch, R_B), b);
      rd(ca(ch, R_A), v);
      checks++;
      if (v !== a) begin failures++; $display("FAIL rand_readback_a t=%0d got=%0d exp=%0d", t, v, a); end
      wr(ca(ch, R_CTRL), 32'd1);
      poll_done(ch, 4000, k);
      checks++;
      if (k !== model_lat(a, b)) begin failures++; $display("FAIL rand_latency t=%0d a=%0d b=%0d got=%0d exp=%0d", t, a, b, k, model_lat(a, b)); end
      rd_now(ca(ch, R_RES), v);
      checks++;
      if (v !== model_gcd(a, b)) begin failures++; $display("FAIL rand_result t=%0d a=%0d b=%0d got=%0d exp=%0d", t, a, b, v, model_gcd(a, b)); end
      rd_now(BASE + R_PEND, v);
      checks++;
      if (v !== (32'd1 << ch)) begin failures++; $display("FAIL rand_pend t=%0d got=%h exp=%h", t, v, 32'd1 << ch); end
      checks++;
      if (irq !== en[ch]) begin failures++; $display("FAIL rand_irq t=%0d got=%b exp=%b", t, irq, en[ch]); end
    end
    wr(BASE + R_PEND, 32'hF);
    wr(BASE + R_EN, 32'h0);
  endtask

  task automatic test_reset_decode;
    logic [31:0] v;
    wr(BASE + R_EN, 32'hF);
    wr(ca(1, R_A), 32'd1000);
    wr(ca(1, R_B), 32'd1);
    wr(ca(1, R_CTRL), 32'd1);
    repeat (10) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", irq); end
    for (int ch = 0; ch < NCH; ch++) begin
      for (int r = 0; r < 4; r++) begin
        rd(ca(ch, 32'(r * 4)), v);
        checks++;
        if (v !== 32'd0) begin failures++; $display("FAIL rst_reg ch%0d off%0d got=%h exp=0", ch, r * 4, v); end
      end
    end
    rd(BASE + R_EN, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL rst_en got=%h exp=0", v); end
    repeat (1100) @(posedge clk);
    rd(BASE + R_PEND, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL rst_no_pend got=%h exp=0", v); end
    rd(ca(1, R_CTRL), v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL rst_idle got=%h exp=0", v); end
    wr(ca(0, R_A), 32'h55);
    wr(BASE + 32'h1F0, 32'h1234);
    rd(BASE + 32'h1F0, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL decode_unmapped got=%h exp=0", v); end
    wr(ca(NCH, R_A), 32'h77);
    rd(ca(NCH, R_A), v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL decode_chan_oob got=%h exp=0", v); end
    wr(32'h0000_E000, 32'h99);
    wr(32'h0001_F000, 32'h99);
    rd(ca(0, R_A), v);
    checks++;
    if (v !== 32'h55) begin failures++; $display("FAIL decode_outside got=%h exp=55", v); end
    rd(32'h0000_E000, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL decode_unselected_read got=%h exp=0", v); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_irq();
    test_concurrency();
    test_overrun();
    test_w1c_race();
    test_random();
    test_reset_decode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
